// File: rtl/mem_access32.sv
// Load/store unit between a core request port and a word-wide memory.
// Handles byte/half/word accesses, sign extension, alignment faults and read-modify-write stores.
module mem_access32 #(
  parameter int unsigned CHECK_ALIGN = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_req_valid,
  output logic        out_req_ready,
  input  logic        in_req_write,
  input  logic [1:0]  in_req_size,
  input  logic        in_req_signed,
  input  logic [31:0] in_req_address,
  input  logic [31:0] in_req_data,
  output logic        out_resp_valid,
  input  logic        in_resp_ready,
  output logic [31:0] out_resp_data,
  output logic        out_resp_exception,
  output logic [31:0] out_mem_read_address,
  input  logic [31:0] in_mem_read_data,
  input  logic        in_mem_read_exception,
  output logic        out_mem_write_enable,
  output logic [31:0] out_mem_write_address,
  output logic [31:0] out_mem_write_data,
  input  logic        in_mem_write_exception
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_data;
  logic [1:0]  r_off;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_wen;
  logic [31:0] r_resp_data;
  logic        r_resp_exc;

  logic        w_mis;
  logic        w_fault;
  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic [4:0]  w_sh;
  logic [31:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  always_comb begin
    w_mis   = (in_req_size == 2'd3)
            | ((in_req_size == 2'd1) & in_req_address[0])
            | ((in_req_size == 2'd2) & (|in_req_address[1:0]));
    w_fault = (CHECK_ALIGN != 0) && w_mis;
    // With checking off, size 3 behaves as a word and offsets are forced onto the access size.
    w_size  = (in_req_size == 2'd3) ? 2'd2 : in_req_size;
    case (w_size)
      2'd0:    w_off = in_req_address[1:0];
      2'd1:    w_off = {in_req_address[1], 1'b0};
      default: w_off = 2'd0;
    endcase
  end

  always_comb begin
    w_sh   = {r_off, 3'b000};
    w_lane = in_mem_read_data >> w_sh;
    case (r_size)
      2'd0:    w_load = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
      2'd1:    w_load = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
    w_mask   = ((r_size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    w_merged = (in_mem_read_data & ~w_mask) | ((r_data << w_sh) & w_mask);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_data      <= '0;
      r_off       <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_wen       <= 1'b0;
      r_resp_data <= '0;
      r_resp_exc  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_req_valid) begin
            r_write    <= in_req_write;
            r_size     <= w_size;
            r_signed   <= in_req_signed;
            r_data     <= in_req_data;
            r_off      <= w_off;
            r_waddr    <= {in_req_address[31:2], 2'b00};
            r_resp_data <= '0;
            r_resp_exc <= 1'b0;
            if (w_fault) begin
              r_resp_exc <= 1'b1;
              r_state    <= RESP;
            end else if (in_req_write && (w_size == 2'd2)) begin
              r_wdata <= in_req_data;
              r_wen   <= 1'b1;
              r_state <= WRITE;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          if (in_mem_read_exception) begin
            r_resp_exc  <= 1'b1;
            r_resp_data <= '0;
            r_state     <= RESP;
          end else if (r_write) begin
            r_wdata <= w_merged;
            r_wen   <= 1'b1;
            r_state <= WRITE;
          end else begin
            r_resp_data <= w_load;
            r_state     <= RESP;
          end
        end
        WRITE: begin
          r_wen       <= 1'b0;
          r_resp_exc  <= in_mem_write_exception;
          r_resp_data <= '0;
          r_state     <= RESP;
        end
        RESP: begin
          if (in_resp_ready) begin
            r_resp_data <= '0;
            r_resp_exc  <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gating with RESET keeps ready low while reset is held, yet high on the first edge after release.
  assign out_req_ready         = (r_state == IDLE) && RESET;
  assign out_resp_valid        = (r_state == RESP);
  assign out_resp_data         = r_resp_data;
  assign out_resp_exception    = r_resp_exc;
  assign out_mem_read_address  = r_waddr;
  assign out_mem_write_enable  = r_wen;
  assign out_mem_write_address = r_waddr;
  assign out_mem_write_data    = r_wdata;

endmodule

// File: tb/tb_mem_access32.sv
// Randomized and directed self-checking bench for mem_access32 against a byte-level reference model.
module tb_mem_access32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_req_valid;
  logic        out_req_ready;
  logic        in_req_write;
  logic [1:0]  in_req_size;
  logic        in_req_signed;
  logic [31:0] in_req_address;
  logic [31:0] in_req_data;
  logic        out_resp_valid;
  logic        in_resp_ready;
  logic [31:0] out_resp_data;
  logic        out_resp_exception;
  logic [31:0] out_mem_read_address;
  logic [31:0] in_mem_read_data;
  logic        in_mem_read_exception;
  logic        out_mem_write_enable;
  logic [31:0] out_mem_write_address;
  logic [31:0] out_mem_write_data;
  logic        in_mem_write_exception;

  mem_access32 #(.CHECK_ALIGN(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
    .in_req_write(in_req_write), .in_req_size(in_req_size),
    .in_req_signed(in_req_signed), .in_req_address(in_req_address),
    .in_req_data(in_req_data), .out_resp_valid(out_resp_valid),
    .in_resp_ready(in_resp_ready), .out_resp_data(out_resp_data),
    .out_resp_exception(out_resp_exception),
    .out_mem_read_address(out_mem_read_address),
    .in_mem_read_data(in_mem_read_data),
    .in_mem_read_exception(in_mem_read_exception),
    .out_mem_write_enable(out_mem_write_enable),
    .out_mem_write_address(out_mem_write_address),
    .out_mem_write_data(out_mem_write_data),
    .in_mem_write_exception(in_mem_write_exception)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          wr_cyc = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  always_comb in_mem_read_data = mem[out_mem_read_address[9:2]];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (poke_en) mem[poke_idx] <= poke_val;
    if (RESET && out_mem_write_enable) begin
      mem[out_mem_write_address[9:2]] <= out_mem_write_data;
      wr_cnt  <= wr_cnt + 1;
      wr_cyc  <= cyc + 1;
      wr_addr <= out_mem_write_address;
      wr_data <= out_mem_write_data;
    end
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    poke_idx = a[9:2];
    poke_val = v;
    poke_en  = 1'b1;
    @(posedge CLK); #1;
    poke_en  = 1'b0;
  endtask

  function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] mw,
                                input logic rx, input logic wx,
                                output logic [31:0] ed, output logic ee, output int el,
                                output int ew, output logic [31:0] ewd);
    int off, n;
    logic [31:0] v, lim;
    off = int'(a % 4);
    ed = '0; ee = 1'b0; ew = 0; ewd = '0;
    if (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && off != 0)) begin
      ee = 1'b1; el = 1;
      return;
    end
    n = 1 << sz;
    if (!w) begin
      el = 2;
      if (rx) begin
        ee = 1'b1;
      end else begin
        v = mw >> (8 * off);
        if (n < 4) begin
          lim = 32'd1 << (8 * n);
          v = v % lim;
          if (sg && v >= lim / 2) v = v - lim;
        end
        ed = v;
      end
    end else if (n == 4) begin
      el = 2; ew = 1; ewd = d; ee = wx;
    end else if (rx) begin
      el = 2; ee = 1'b1;
    end else begin
      el = 3; ew = 1; ee = wx; ewd = mw;
      for (int i = 0; i < n; i++) ewd[8*(off+i) +: 8] = d[8*i +: 8];
    end
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic rex,
                       output int wdelta, output int wofs, output logic to);
    int n, w0, ac;
    to = 1'b0;
    in_req_write = w; in_req_size = sz; in_req_signed = sg;
    in_req_address = a; in_req_data = d; in_req_valid = 1'b1;
    n = 0;
    while (!out_req_ready && n < 20) begin @(posedge CLK); #1; n++; end
    if (!out_req_ready) to = 1'b1;
    @(posedge CLK); #1;
    in_req_valid = 1'b0;
    ac = cyc; w0 = wr_cnt;
    lat = 1;
    while (!out_resp_valid && lat < 20) begin @(posedge CLK); #1; lat++; end
    if (!out_resp_valid) to = 1'b1;
    rd = out_resp_data; rex = out_resp_exception;
    in_resp_ready = 1'b1;
    @(posedge CLK); #1;
    in_resp_ready = 1'b0;
    wdelta = wr_cnt - w0;
    wofs = wr_cyc - ac;
  endtask

  task automatic test_reset();
    int lat;
    RESET = 1'b0;
    #12;
    n_checks++;
    if (out_req_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", out_req_ready);
    else n_pass++;
    n_checks++;
    if ({out_resp_valid, out_resp_data, out_resp_exception, out_mem_write_enable,
         out_mem_read_address, out_mem_write_address, out_mem_write_data} !== '0)
      $display("FAIL reset_outputs got=%b/%h/%b/%b/%h/%h/%h exp=all zero", out_resp_valid,
               out_resp_data, out_resp_exception, out_mem_write_enable, out_mem_read_address,
               out_mem_write_address, out_mem_write_data);
    else n_pass++;
    poke(32'h10, 32'h1234_5678);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_checks++;
    if (out_req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", out_req_ready);
    else n_pass++;
    in_req_write = 1'b0; in_req_size = 2'd2; in_req_signed = 1'b0;
    in_req_address = 32'h10; in_req_data = '0; in_req_valid = 1'b1;
    @(posedge CLK); #1;
    in_req_valid = 1'b0;
    n_checks++;
    if (out_req_ready !== 1'b0) $display("FAIL first_accept got_ready=%b exp=0", out_req_ready);
    else n_pass++;
    lat = 1;
    while (!out_resp_valid && lat < 20) begin @(posedge CLK); #1; lat++; end
    n_checks++;
    if (out_resp_data !== 32'h1234_5678 || lat != 2)
      $display("FAIL first_load got=%h lat=%0d exp=12345678 lat=2", out_resp_data, lat);
    else n_pass++;
    in_resp_ready = 1'b1;
    @(posedge CLK); #1;
    in_resp_ready = 1'b0;
  endtask

  task automatic test_load_byte_signed();
    int lat, wd, wo; logic [31:0] rd; logic rex, to;
    poke(32'h100, 32'h80FF_7F01);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, lat, rd, rex, wd, wo, to);
    n_checks++;
    if (to || rd !== 32'hFFFF_FF80 || rex !== 1'b0 || lat != 2 || wd != 0)
      $display("FAIL load_byte_signed got=%h exc=%b lat=%0d wr=%0d to=%b exp=ffffff80 exc=0 lat=2 wr=0",
               rd, rex, lat, wd, to);
    else n_pass++;
  endtask

  task automatic test_store_half();
    int lat, wd, wo; logic [31:0] rd; logic rex, to;
    poke(32'h200, 32'h1122_3344);
    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, lat, rd, rex, wd, wo, to);
    n_checks++;
    if (to || wd != 1 || wr_addr !== 32'h200 || wr_data !== 32'hBEEF_3344)
      $display("FAIL store_half_write got=%0d/%h/%h exp=1/00000200/beef3344", wd, wr_addr, wr_data);
    else n_pass++;
    n_checks++;
    if (rd !== 32'h0 || rex !== 1'b0 || lat != 3 || wo != 2)
      $display("FAIL store_half_resp got=%h exc=%b lat=%0d wofs=%0d exp=0 exc=0 lat=3 wofs=2",
               rd, rex, lat, wo);
    else n_pass++;
  endtask

  task automatic test_store_word();
    int lat, wd, wo; logic [31:0] rd; logic rex, to;
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, lat, rd, rex, wd, wo, to);
    n_checks++;
    if (to || wd != 1 || wo != 1 || wr_addr !== 32'h40 || wr_data !== 32'hCAFE_F00D || lat != 2)
      $display("FAIL store_word got=%0d wofs=%0d %h/%h lat=%0d exp=1 wofs=1 00000040/cafef00d lat=2",
               wd, wo, wr_addr, wr_data, lat);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    int lat, wd, wo; logic [31:0] rd; logic rex, to;
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, lat, rd, rex, wd, wo, to);
    n_checks++;
    if (to || rex !== 1'b1 || rd !== 32'h0 || lat != 1 || wd != 0)
      $display("FAIL misaligned got=exc%b/%h lat=%0d wr=%0d exp=exc1/0 lat=1 wr=0", rex, rd, lat, wd);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n; logic [31:0] d0;
    poke(32'h80, 32'hA5C3_9001);
    in_req_write = 1'b0; in_req_size = 2'd1; in_req_signed = 1'b0;
    in_req_address = 32'h82; in_req_valid = 1'b1;
    @(posedge CLK); #1;
    in_req_valid = 1'b0;
    n = 0;
    while (!out_resp_valid && n < 20) begin @(posedge CLK); #1; n++; end
    d0 = out_resp_data;
    n_checks++;
    if (d0 !== 32'h0000_A5C3) $display("FAIL bp_data got=%h exp=0000a5c3", d0);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (out_resp_valid !== 1'b1 || out_resp_data !== d0 || out_req_ready !== 1'b0)
        $display("FAIL bp_hold cycle=%0d got=%b/%h/%b exp=1/%h/0", i, out_resp_valid,
                 out_resp_data, out_req_ready, d0);
      else n_pass++;
    end
    in_resp_ready = 1'b1;
    @(posedge CLK); #1;
    in_resp_ready = 1'b0;
    n_checks++;
    if (out_req_ready !== 1'b1 || out_resp_valid !== 1'b0)
      $display("FAIL bp_release got=%b/%b exp=ready1/valid0", out_req_ready, out_resp_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    poke(32'h30, 32'h4433_2211);
    poke(32'h34, 32'hDEAD_BEEF);
    in_req_write = 1'b0; in_req_size = 2'd0; in_req_signed = 1'b0;
    in_req_address = 32'h31; in_req_valid = 1'b1;
    @(posedge CLK); #1;
    in_req_size = 2'd2; in_req_address = 32'h34;
    n = 0;
    while (!out_resp_valid && n < 20) begin @(posedge CLK); #1; n++; end
    n_checks++;
    if (out_resp_data !== 32'h22) $display("FAIL b2b_first got=%h exp=00000022", out_resp_data);
    else n_pass++;
    in_resp_ready = 1'b1;
    @(posedge CLK); #1;
    in_resp_ready = 1'b0;
    n_checks++;
    if (out_req_ready !== 1'b1 || out_resp_valid !== 1'b0)
      $display("FAIL b2b_gap got=ready%b/valid%b exp=ready1/valid0", out_req_ready, out_resp_valid);
    else n_pass++;
    @(posedge CLK); #1;
    in_req_valid = 1'b0;
    n_checks++;
    if (out_req_ready !== 1'b0) $display("FAIL b2b_second_accept got=%b exp=0", out_req_ready);
    else n_pass++;
    n = 0;
    while (!out_resp_valid && n < 20) begin @(posedge CLK); #1; n++; end
    n_checks++;
    if (out_resp_data !== 32'hDEAD_BEEF) $display("FAIL b2b_second got=%h exp=deadbeef", out_resp_data);
    else n_pass++;
    in_resp_ready = 1'b1;
    @(posedge CLK); #1;
    in_resp_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat, wd, wo, el, ew; logic [31:0] rd, a, d, mw, ed, ewd; logic rex, to, ee;
    logic w, sg, rx, wx; logic [1:0] sz;
    for (int it = 0; it < 60; it++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1023));
      d  = $urandom;
      mw = $urandom;
      rx = ($urandom_range(0, 7) == 0);
      wx = ($urandom_range(0, 7) == 0);
      poke(a, mw);
      in_mem_read_exception = rx;
      in_mem_write_exception = wx;
      issue(w, sz, sg, a, d, lat, rd, rex, wd, wo, to);
      in_mem_read_exception = 1'b0;
      in_mem_write_exception = 1'b0;
      model(w, sz, sg, a, d, mw, rx, wx, ed, ee, el, ew, ewd);
      n_checks++;
      if (to || rd !== ed || rex !== ee || lat != el)
        $display("FAIL rand_resp it=%0d w=%b sz=%0d a=%h got=%h/%b lat=%0d exp=%h/%b lat=%0d to=%b",
                 it, w, sz, a, rd, rex, lat, ed, ee, el, to);
      else n_pass++;
      n_checks++;
      if (wd != ew) $display("FAIL rand_wcount it=%0d got=%0d exp=%0d", it, wd, ew);
      else n_pass++;
      if (ew == 1) begin
        n_checks++;
        if (wr_data !== ewd || wr_addr !== (a & ~32'd3) || wo != el - 1)
          $display("FAIL rand_write it=%0d got=%h@%h ofs=%0d exp=%h@%h ofs=%0d", it, wr_data,
                   wr_addr, wo, ewd, a & ~32'd3, el - 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_in_write();
    int n, w0; logic seen;
    poke(32'h140, 32'h5566_7788);
    in_req_write = 1'b1; in_req_size = 2'd0; in_req_signed = 1'b0;
    in_req_address = 32'h141; in_req_data = 32'h0000_00AB; in_req_valid = 1'b1;
    @(posedge CLK); #1;
    in_req_valid = 1'b0;
    n = 0;
    while (!out_mem_write_enable && n < 10) begin @(posedge CLK); #1; n++; end
    seen = out_mem_write_enable;
    n_checks++;
    if (seen !== 1'b1) $display("FAIL rw_reach_write got=%b exp=1", seen);
    else n_pass++;
    w0 = wr_cnt;
    #2 RESET = 1'b0;
    #1;
    n_checks++;
    if (out_mem_write_enable !== 1'b0 || out_req_ready !== 1'b0 || out_resp_valid !== 1'b0)
      $display("FAIL rw_async_drop got=we%b/rdy%b/rv%b exp=0/0/0", out_mem_write_enable,
               out_req_ready, out_resp_valid);
    else n_pass++;
    @(posedge CLK); #1;
    n_checks++;
    if (wr_cnt != w0 || mem[8'h50] !== 32'h5566_7788)
      $display("FAIL rw_no_write got=%0d/%h exp=%0d/55667788", wr_cnt, mem[8'h50], w0);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_checks++;
    if (out_req_ready !== 1'b1) $display("FAIL rw_ready_after got=%b exp=1", out_req_ready);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (out_resp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL rw_no_resp got=%b exp=0", seen);
    else n_pass++;
  endtask

  initial begin
    in_req_valid = 1'b0; in_req_write = 1'b0; in_req_size = '0; in_req_signed = 1'b0;
    in_req_address = '0; in_req_data = '0; in_resp_ready = 1'b0;
    in_mem_read_exception = 1'b0; in_mem_write_exception = 1'b0;
    test_reset();
    test_load_byte_signed();
    test_store_half();
    test_store_word();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_in_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
